shift_timer_ctrl: RTL and testbench
===================================

# shift_timer_ctrl

Sequencing controller for the serial delay-shift datapath. It watches a serial `data` stream for a start pattern. It then asserts `shift_ena` for exactly `SHIFT_LEN` cycles while capturing the delay field, and runs a timed count of `(delay+1)*TICKS_PER_UNIT` cycles. Finally it holds `done` until the user acknowledges. It sits directly above the shift/count datapath and is the sole driver of its enables.

## Interface
- `PATTERN`, 4'b1101, start pattern; the last `PAT_W` serial bits are compared against it, MSB first.
- `PAT_W`, 4, pattern width (≥2).
- `SHIFT_LEN`, 4, number of shift cycles; also the width of `delay`.
- `TICKS_PER_UNIT`, 1000, clock cycles per delay unit (≥1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data`  in  1  serial input stream.
- `ack`  in  1  user acknowledge of `done`.
- `shift_ena`  out  1  high during the SHIFT state.
- `counting`  out  1  high during the COUNT state.
- `done`  out  1  high during the WAIT_ACK state.
- `delay`  out  SHIFT_LEN  captured delay value, MSB first.

## Operation
- Moore FSM with states SEARCH, SHIFT, COUNT and WAIT_ACK. Outputs `shift_ena`, `counting` and `done` decode from the state register only.
- **SEARCH**
  - `hist[PAT_W-2:0] <= {hist[PAT_W-3:0], data}` every cycle.
  - On a match, `{hist, data} == PATTERN`, go to SHIFT next cycle and clear `hist`.
  - Matching is continuous: a prefix that fails does not reset `hist`. For example, stream 1,1,1,0,1 matches on the last bit.
- **SHIFT**
  - Each cycle: `delay <= {delay[SHIFT_LEN-2:0], data}` and the shift counter increments.
  - After exactly `SHIFT_LEN` cycles, go to COUNT and load `tick = 0`.
- **COUNT**
  - `tick` runs 0..TICKS_PER_UNIT-1.
  - On wrap with `delay != 0`: `delay <= delay-1`.
  - On wrap with `delay == 0`: go to WAIT_ACK.
  - Total time in COUNT is `(delay_captured+1)*TICKS_PER_UNIT` cycles.
- **WAIT_ACK**
  - `done` is held high.
  - When `ack` is sampled high, go to SEARCH.
- `ack` is ignored outside WAIT_ACK. `data` is ignored in COUNT and WAIT_ACK.
- `tick` width is `$clog2(TICKS_PER_UNIT)`, with a minimum of 1 bit. All counters are unsigned, with no wrap beyond the stated bounds.

## Timing
- **Reset values:** state = SEARCH; `hist`, `delay`, shift counter and `tick` all 0. Outputs: `shift_ena = 0`, `counting = 0`, `done = 0`, `delay = 0`.
- **Reset mid-operation:** any state returns to SEARCH immediately. No partial delay is retained.
- **Shift latency:** `shift_ena` rises on the first rising edge after the cycle in which the final pattern bit is present. It stays high for exactly `SHIFT_LEN` cycles.
- **Delay capture:** data bits sampled in those `SHIFT_LEN` cycles form `delay`, first bit as MSB.
- **Count timing:** `counting` rises in the cycle after the last shift cycle.
- **Done timing:** `done` rises in the cycle after the last count cycle.
- **Ack timing:** `ack` high at edge N means `done` is low from N onward, and pattern search resumes in that cycle.
- **Back-to-back patterns:** ack and a new pattern are not overlapped. `hist` starts from 0, so at least `PAT_W` SEARCH cycles are needed before the next SHIFT.
- **Ack boundaries:** `ack` held high continuously gives a single pass through WAIT_ACK of 1 cycle. `ack` asserted during COUNT has no effect.

## Configuration
- `SHIFT_TIMER_COUNT_OUT_EN`
  - **Defined:** adds output port `count [SHIFT_LEN-1:0]` equal to `delay` during COUNT (remaining whole units), and 0 in all other states.
  - **Not defined:** the port is absent; behaviour is otherwise identical.

## Structure
- Shared package `shift_timer_pkg` holds:
  - the state enum `st_e` (SEARCH, SHIFT, COUNT, WAIT_ACK);
  - default constants `PATTERN_DEF`, `SHIFT_LEN_DEF` and `TICKS_PER_UNIT_DEF`.
- One natural sub-module: `shift_timer_patdet`, the pattern history register plus comparator. It has a clear input and a `match` output.

## Test plan
All scenarios use `TICKS_PER_UNIT = 4` and default values for the other parameters.

- **Reset:** drive `resetn = 0` mid-COUNT, asynchronously between edges → all outputs 0 immediately, and state is SEARCH after release.
- **Nominal run:** data 1,1,0,1 then 0,1,0,1 → `shift_ena` high exactly 4 cycles, `delay = 4'b0101`, `counting` high exactly 24 cycles, then `done` high until `ack`.
- **Overlapping prefix:** stream 1,1,1,0,1 → `shift_ena` rises the cycle after the final 1. Stream 1,1,0,0,1,1,0,1 → single match, at the 8th bit only.
- **Delay zero:** shift bits 0,0,0,0 → `counting` high exactly 4 cycles. With the macro defined, `count == 0` throughout.
- **Ack handling:** `ack` pulsed during SHIFT and during COUNT → ignored. `ack` held high entering WAIT_ACK → `done` high 1 cycle, then SEARCH, with no spurious `shift_ena`.
- **Max delay:** shift bits 1,1,1,1 → `counting` high exactly 64 cycles. With the macro defined, `count` steps 15→0, decrementing every 4 cycles.

Source files
------------

// File: rtl/shift_timer_pkg.sv
// shift_timer_pkg: shared state encoding and default parameters for the shift timer controller
package shift_timer_pkg;

    localparam logic [3:0] PATTERN_DEF        = 4'b1101;
    localparam int         SHIFT_LEN_DEF      = 4;
    localparam int         TICKS_PER_UNIT_DEF = 1000;

    localparam logic [1:0] ST_SEARCH   = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_COUNT    = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    typedef enum logic [1:0] {
        SEARCH   = ST_SEARCH,
        SHIFT    = ST_SHIFT,
        COUNT    = ST_COUNT,
        WAIT_ACK = ST_WAIT_ACK
    } st_e;

endpackage

// File: rtl/shift_timer_patdet.sv
// shift_timer_patdet: serial history register and start-pattern comparator
module shift_timer_patdet
    import shift_timer_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clear,
    input  logic data,
    output logic match
);

    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] win;

    assign win   = {hist, data};
    assign match = en && (win == PATTERN);

    // keep the last PAT_W-1 bits; a failed prefix never resets the history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            hist <= '0;
        else if (clear)
            hist <= '0;
        else if (en)
            hist <= win[PAT_W-2:0];
    end

endmodule

// File: rtl/shift_timer_ctrl.sv
// shift_timer_ctrl: pattern-triggered delay capture and timed count; SHIFT_TIMER_COUNT_OUT_EN adds the count port
module shift_timer_ctrl
    import shift_timer_pkg::*;
#(
    parameter int               PAT_W          = 4,
    parameter logic [PAT_W-1:0] PATTERN        = PATTERN_DEF,
    parameter int               SHIFT_LEN      = SHIFT_LEN_DEF,
    parameter int               TICKS_PER_UNIT = TICKS_PER_UNIT_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 data,
    input  logic                 ack,
    output logic                 shift_ena,
    output logic                 counting,
    output logic                 done,
    output logic [SHIFT_LEN-1:0] delay
`ifdef SHIFT_TIMER_COUNT_OUT_EN
    ,
    output logic [SHIFT_LEN-1:0] count
`endif
);

    localparam int SC_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam int TW   = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SHIFT_LEN - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_UNIT - 1);

    st_e              state;
    logic [SC_W-1:0]  sc;
    logic [TW-1:0]    tick;
    logic [SHIFT_LEN:0] dcat;
    logic             match;

    assign dcat = {delay, data};

    shift_timer_patdet #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_patdet (
        .clk    (clk),
        .resetn (resetn),
        .en     (state == SEARCH),
        .clear  (match),
        .data   (data),
        .match  (match)
    );

    // sequencing FSM with shift counter, tick counter and delay register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SEARCH;
            sc    <= '0;
            tick  <= '0;
            delay <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        state <= SHIFT;
                        sc    <= '0;
                    end
                end
                SHIFT: begin
                    delay <= dcat[SHIFT_LEN-1:0];
                    sc    <= sc + 1'b1;
                    if (sc == SC_LAST) begin
                        state <= COUNT;
                        sc    <= '0;
                        tick  <= '0;
                    end
                end
                COUNT: begin
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (delay != '0)
                            delay <= delay - 1'b1;
                        else
                            state <= WAIT_ACK;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack)
                        state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign shift_ena = (state == SHIFT);
    assign counting  = (state == COUNT);
    assign done      = (state == WAIT_ACK);

`ifdef SHIFT_TIMER_COUNT_OUT_EN
    assign count = counting ? delay : '0;
`endif

endmodule

// File: tb/tb_shift_timer_ctrl.sv
// tb_shift_timer_ctrl: directed self-checking bench for shift_timer_ctrl with TICKS_PER_UNIT = 4
module tb_shift_timer_ctrl;

    localparam int TPU = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic       data   = 1'b0;
    logic       ack    = 1'b0;
    logic       shift_ena, counting, done;
    logic [3:0] delay;
`ifdef SHIFT_TIMER_COUNT_OUT_EN
    logic [3:0] count;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    shift_timer_ctrl #(
        .TICKS_PER_UNIT (TPU)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data      (data),
        .ack       (ack),
        .shift_ena (shift_ena),
        .counting  (counting),
        .done      (done),
        .delay     (delay)
`ifdef SHIFT_TIMER_COUNT_OUT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic a);
        data = d;
        ack  = a;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] bits, input int len, input string tag);
        for (int i = len - 1; i >= 0; i--) begin
            chk({tag, "_no_early_shift"}, int'(shift_ena), 0);
            cyc(bits[i], 1'b0);
        end
        chk({tag, "_shift_rise"}, int'(shift_ena), 1);
    endtask

    task automatic shift4(input logic [3:0] b, input logic a_mid);
        for (int i = 3; i >= 0; i--) begin
            chk("shift_ena_high", int'(shift_ena), 1);
            cyc(b[i], (i == 2) ? a_mid : 1'b0);
        end
        chk("shift_ena_fall", int'(shift_ena), 0);
        chk("counting_rise", int'(counting), 1);
        chk("delay_captured", int'(delay), int'(b));
    endtask

    // mode 0: ack low, 1: ack pulsed, 2: ack held high
    task automatic measure(input int mode, input int d0, output int len);
        len = 0;
        while (counting && len < 200) begin
`ifdef SHIFT_TIMER_COUNT_OUT_EN
            chk("count_value", int'(count), d0 - len / TPU);
`endif
            len++;
            cyc(len % 3 == 0, (mode == 2) || (mode == 1 && len % 2 == 0));
        end
        chk("done_rise", int'(done), 1);
        chk("delay_drained", int'(delay), 0);
`ifdef SHIFT_TIMER_COUNT_OUT_EN
        chk("count_zero_in_done", int'(count), 0);
`endif
    endtask

    initial begin
        #2 resetn = 1'b0;
        #10;
        chk("reset_shift_ena", int'(shift_ena), 0);
        chk("reset_counting", int'(counting), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_delay", int'(delay), 0);
        @(negedge clk);
        resetn = 1'b1;

        send(8'b1101, 4, "nominal");
        shift4(4'b0101, 1'b0);
        measure(0, 5, n);
        chk("nominal_count_len", n, 24);
        cyc(0, 0);
        cyc(0, 0);
        chk("done_held", int'(done), 1);
        cyc(0, 1);
        chk("done_cleared_by_ack", int'(done), 0);

        send(8'b11101, 5, "overlap5");
        shift4(4'b0000, 1'b0);
        measure(0, 0, n);
        chk("zero_delay_count_len", n, 4);
        cyc(0, 1);
        chk("zero_delay_ack", int'(done), 0);

        send(8'b11001101, 8, "overlap8");
        shift4(4'b1111, 1'b1);
        measure(1, 15, n);
        chk("max_delay_count_len", n, 64);
        cyc(0, 1);
        chk("max_delay_ack", int'(done), 0);

        send(8'b1101, 4, "ackheld");
        shift4(4'b0000, 1'b0);
        measure(2, 0, n);
        chk("ackheld_count_len", n, 4);
        cyc(0, 1);
        chk("ackheld_done_one_cycle", int'(done), 0);
        for (int i = 0; i < 5; i++) begin
            chk("ackheld_no_shift", int'(shift_ena), 0);
            chk("ackheld_no_done", int'(done), 0);
            cyc(0, 1);
        end
        cyc(0, 0);

        send(8'b1101, 4, "prereset");
        shift4(4'b1111, 1'b0);
        repeat (5) cyc(0, 0);
        chk("midcount_counting", int'(counting), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_counting", int'(counting), 0);
        chk("async_reset_done", int'(done), 0);
        chk("async_reset_shift_ena", int'(shift_ena), 0);
        chk("async_reset_delay", int'(delay), 0);
        @(negedge clk);
        resetn = 1'b1;
        send(8'b1101, 4, "postreset");
        shift4(4'b0010, 1'b0);
        measure(0, 2, n);
        chk("postreset_count_len", n, 12);
        cyc(0, 1);
        chk("postreset_ack", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
